ipbase_intf_axi_rd_wrr_sched_v0p1: RTL



---
 rtl/ipbase_intf_axi_rd_wrr_sched_pkg.sv | 20 ++
 rtl/ipbase_intf_axi_ostd_cnt.sv | 40 ++++
 rtl/ipbase_intf_axi_rd_wrr_sched_v0p1.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ipbase_intf_axi_rd_wrr_sched_pkg.sv
// Shared types and constants for the AXI read-address WRR scheduler.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package ipbase_intf_axi_rd_wrr_sched_pkg;

  // Which requester currently holds priority.
  typedef enum logic {
    SERVE0 = 1'b0,
    SERVE1 = 1'b1
  } serve_e;

  // A programmed weight of zero behaves as this value.
  localparam int DEFAULT_WEIGHT = 1;

  // Width needed to hold an outstanding count in the range 0..max_ostd.
  function automatic int ostd_cnt_w(input int max_ostd);
    return $clog2(max_ostd + 1);
  endfunction

endpackage

// File: rtl/ipbase_intf_axi_ostd_cnt.sv
// Per-source outstanding-burst counter: +1 on grant, -1 on retire, saturating at 0.
// Latency: count updates one cycle after inc/dec; full and err are combinational.
// Backpressure: full tells the arbiter to stop granting this source.
// Ports: sys_clk/sys_rst clock and async reset; inc/dec events; cnt live count;
//        full when cnt reaches MAX_OSTD; err pulses on a retire that finds the count at 0.
module ipbase_intf_axi_ostd_cnt
  import ipbase_intf_axi_rd_wrr_sched_pkg::*;
#(
  parameter int MAX_OSTD = 8,
  parameter int CNT_W    = ostd_cnt_w(MAX_OSTD)
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_OSTD);

  logic [CNT_W-1:0] cnt_q;

  assign full = (cnt_q >= MAX_V);
  // A simultaneous inc cancels the retire, so only a lone retire at 0 is an error.
  assign err  = dec & ~inc & (cnt_q == '0);
  assign cnt  = cnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (inc & ~dec & ~full) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec & ~inc & (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/ipbase_intf_axi_rd_wrr_sched_v0p1.sv
// Weighted round-robin AR scheduler for two read requesters onto one AXI4 master AR port.
// Latency: grant in cycle N drives m_axi_arvalid in cycle N+1; one burst per cycle sustained.
// Backpressure: no grant while the single AR slot is occupied and m_axi_arready is low.
// Ports: sys_clk/sys_rst; cfg_weight0/1 grant budgets; s00/s01 AR request channels with
//        combinational arready grants; m_axi_ar* registered AR slot; m_axi_r* monitor taps;
//        ostd_cnt0/1 outstanding counts; ostd_err sticky accounting error.
// Optional: IPBASE_AXI_RD_WRR_SCHED_DFX_EN adds dfx_cfg0 (bit0 clears) and dfx_sta0 counters.
module ipbase_intf_axi_rd_wrr_sched_v0p1
  import ipbase_intf_axi_rd_wrr_sched_pkg::*;
#(
  parameter int S00_AXI_ID_SET = 0,
  parameter int S01_AXI_ID_SET = 1,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_OSTD       = 8,
  parameter int WEIGHT_WIDTH   = 4
) (
  input  logic                                  sys_clk,
  input  logic                                  sys_rst,
`ifdef IPBASE_AXI_RD_WRR_SCHED_DFX_EN
  input  logic [31:0]                           dfx_cfg0,
  output logic [31:0]                           dfx_sta0,
`endif
  input  logic [WEIGHT_WIDTH-1:0]               cfg_weight0,
  input  logic [WEIGHT_WIDTH-1:0]               cfg_weight1,
  input  logic [AXI_ID_WIDTH-1:0]               s00_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]             s00_axi_araddr,
  input  logic [7:0]                            s00_axi_arlen,
  input  logic                                  s00_axi_arvalid,
  output logic                                  s00_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]               s01_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]             s01_axi_araddr,
  input  logic [7:0]                            s01_axi_arlen,
  input  logic                                  s01_axi_arvalid,
  output logic                                  s01_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]               m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]             m_axi_araddr,
  output logic [7:0]                            m_axi_arlen,
  output logic                                  m_axi_arvalid,
  input  logic                                  m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]               m_axi_rid,
  input  logic                                  m_axi_rlast,
  input  logic                                  m_axi_rvalid,
  input  logic                                  m_axi_rready,
  output logic [ostd_cnt_w(MAX_OSTD)-1:0]       ostd_cnt0,
  output logic [ostd_cnt_w(MAX_OSTD)-1:0]       ostd_cnt1,
  output logic                                  ostd_err
);

  localparam logic [AXI_ID_WIDTH-1:0] ID0 = AXI_ID_WIDTH'(S00_AXI_ID_SET);
  localparam logic [AXI_ID_WIDTH-1:0] ID1 = AXI_ID_WIDTH'(S01_AXI_ID_SET);

  serve_e                  state_q, state_d;
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WEIGHT_WIDTH-1:0] w0, w1, w_sel;
  logic [WEIGHT_WIDTH:0]   n_cnt;

  logic slot_free, elig0, elig1;
  logic gnt_vld, gnt_src;
  logic full0, full1, cnt_err0, cnt_err1;
  logic r_done, rid_hit0, rid_hit1, rid_miss;
  logic err_q;

  assign w0 = (cfg_weight0 == '0) ? WEIGHT_WIDTH'(DEFAULT_WEIGHT) : cfg_weight0;
  assign w1 = (cfg_weight1 == '0) ? WEIGHT_WIDTH'(DEFAULT_WEIGHT) : cfg_weight1;

  // The slot may be refilled in the same cycle its current burst handshakes.
  assign slot_free = ~m_axi_arvalid | m_axi_arready;
  // Reset gating keeps arready low while reset is asserted, independent of any flop.
  assign elig0 = s00_axi_arvalid & ~full0 & slot_free & ~sys_rst;
  assign elig1 = s01_axi_arvalid & ~full1 & slot_free & ~sys_rst;

  // FSM: state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= SERVE0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. A run continues only while the same source keeps winning;
  // weights are read live so a lowered weight ends the run on the next grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_sel   = w0;
    n_cnt   = '0;
    if (gnt_vld) begin
      w_sel = gnt_src ? w1 : w0;
      n_cnt = (gnt_src == state_q) ? ({1'b0, cnt_q} + 1'b1) : (WEIGHT_WIDTH+1)'(1);
      if (n_cnt >= {1'b0, w_sel}) begin
        state_d = gnt_src ? SERVE0 : SERVE1;
        cnt_d   = '0;
      end else begin
        state_d = gnt_src ? SERVE1 : SERVE0;
        cnt_d   = n_cnt[WEIGHT_WIDTH-1:0];
      end
    end
  end

  // FSM: outputs. Priority source first, the other one only as a fallback.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = 1'b0;
    if (state_q == SERVE0) begin
      if (elig0) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b0;
      end else if (elig1) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b1;
      end
    end else begin
      if (elig1) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b1;
      end else if (elig0) begin
        gnt_vld = 1'b1;
        gnt_src = 1'b0;
      end
    end
    s00_axi_arready = gnt_vld & ~gnt_src;
    s01_axi_arready = gnt_vld &  gnt_src;
  end

  // AR output slot; payload is only written on a grant, so it holds while stalled.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_axi_arvalid <= 1'b0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
    end else if (gnt_vld) begin
      m_axi_arvalid <= 1'b1;
      m_axi_arid    <= gnt_src ? s01_axi_arid   : s00_axi_arid;
      m_axi_araddr  <= gnt_src ? s01_axi_araddr : s00_axi_araddr;
      m_axi_arlen   <= gnt_src ? s01_axi_arlen  : s00_axi_arlen;
    end else if (slot_free) begin
      m_axi_arvalid <= 1'b0;
    end
  end

  // Burst retirement seen on the R channel.
  assign r_done   = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign rid_hit0 = r_done & (m_axi_rid == ID0);
  assign rid_hit1 = r_done & (m_axi_rid == ID1);
  assign rid_miss = r_done & ~(m_axi_rid == ID0) & ~(m_axi_rid == ID1);

  ipbase_intf_axi_ostd_cnt #(.MAX_OSTD(MAX_OSTD)) u_ostd0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (s00_axi_arready),
    .dec     (rid_hit0),
    .cnt     (ostd_cnt0),
    .full    (full0),
    .err     (cnt_err0)
  );

  ipbase_intf_axi_ostd_cnt #(.MAX_OSTD(MAX_OSTD)) u_ostd1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .inc     (s01_axi_arready),
    .dec     (rid_hit1),
    .cnt     (ostd_cnt1),
    .full    (full1),
    .err     (cnt_err1)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_q <= 1'b0;
    end else if (cnt_err0 | cnt_err1 | rid_miss) begin
      err_q <= 1'b1;
    end
  end

  assign ostd_err = err_q;

`ifdef IPBASE_AXI_RD_WRR_SCHED_DFX_EN
  logic [11:0] dfx_gnt0_q, dfx_gnt1_q;
  logic [7:0]  dfx_stall_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dfx_gnt0_q  <= '0;
      dfx_gnt1_q  <= '0;
      dfx_stall_q <= '0;
    end else if (dfx_cfg0[0]) begin
      dfx_gnt0_q  <= '0;
      dfx_gnt1_q  <= '0;
      dfx_stall_q <= '0;
    end else begin
      if (s00_axi_arready && (dfx_gnt0_q != 12'hFFF)) dfx_gnt0_q <= dfx_gnt0_q + 12'd1;
      if (s01_axi_arready && (dfx_gnt1_q != 12'hFFF)) dfx_gnt1_q <= dfx_gnt1_q + 12'd1;
      if (m_axi_arvalid && !m_axi_arready && (dfx_stall_q != 8'hFF))
        dfx_stall_q <= dfx_stall_q + 8'd1;
    end
  end

  assign dfx_sta0 = {dfx_gnt0_q, dfx_gnt1_q, dfx_stall_q};
`endif

endmodule
